// File: rtl/trap_redirect.sv
// Trap/mret redirect sequencer: drains the LSU, flushes the pipeline, then hands the
// computed target PC (mtvec direct/vectored or mepc) to fetch over valid/ready.
module trap_redirect #(
  parameter int unsigned DRAIN_TIMEOUT = 16,
  parameter int unsigned FLUSH_CYCLES  = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             trap_req,
  input  logic             mret_req,
  input  logic [31:0]      trap_cause,
  input  logic [31:0]      trap_pc,
  input  logic [31:0]      mtvec,
  input  logic [31:0]      mepc,
  input  logic             lsu_busy,
  input  logic             fetch_ready,
  output logic             trap_busy,
  output logic             pipe_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      last_trap_pc,
  output logic [CNT_W-1:0] trap_count,
  output logic             drain_timeout
);

  localparam int unsigned SeqMax = (DRAIN_TIMEOUT > FLUSH_CYCLES) ? DRAIN_TIMEOUT : FLUSH_CYCLES;
  localparam int unsigned SeqW   = $clog2(SeqMax + 1);
  localparam logic [SeqW-1:0] DrainLast = SeqW'(DRAIN_TIMEOUT - 1);
  localparam logic [SeqW-1:0] FlushLast = SeqW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrain, StFlush, StRedirect} state_e;

  state_e            state_q, state_d;
  logic [SeqW-1:0]   seq_cnt_q, seq_cnt_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [31:0]       last_trap_pc_q, last_trap_pc_d;
  logic [CNT_W-1:0]  trap_count_q, trap_count_d;
  logic              drain_timeout_q, drain_timeout_d;

  logic              accept;
  logic              drain_at_limit;
  logic [31:0]       tvec_base;
  logic [31:0]       trap_target;

  assign accept         = (state_q == StIdle) && (trap_req || mret_req);
  assign drain_at_limit = (state_q == StDrain) && (seq_cnt_q == DrainLast);
  assign tvec_base      = {mtvec[31:2], 2'b00};
  // Only interrupts in vectored mode get an offset; modes 2/3 behave as direct.
  assign trap_target    = (mtvec[1:0] == 2'b01 && trap_cause[31])
                          ? tvec_base + {trap_cause[29:0], 2'b00}
                          : tvec_base;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (trap_req || mret_req) begin
          state_d = lsu_busy ? StDrain : StFlush;
        end
      end
      StDrain: begin
        if (!lsu_busy || drain_at_limit) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (seq_cnt_q == FlushLast) begin
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        if (fetch_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    trap_busy      = (state_q != StIdle);
    pipe_flush     = (state_q == StFlush);
    redirect_valid = (state_q == StRedirect);
  end

  // Datapath next-state
  always_comb begin
    seq_cnt_d       = '0;
    redirect_pc_d   = redirect_pc_q;
    last_trap_pc_d  = last_trap_pc_q;
    trap_count_d    = trap_count_q;
    drain_timeout_d = drain_timeout_q;

    // Sequencing counter restarts on every state change.
    if (state_d == state_q && (state_q == StDrain || state_q == StFlush)) begin
      seq_cnt_d = seq_cnt_q + SeqW'(1);
    end

    if (accept) begin
      if (trap_req) begin
        redirect_pc_d  = trap_target;
        last_trap_pc_d = trap_pc;
        if (trap_count_q != '1) begin
          trap_count_d = trap_count_q + CNT_W'(1);
        end
      end else begin
        redirect_pc_d = {mepc[31:2], 2'b00};
      end
    end

    if (drain_at_limit && lsu_busy) begin
      drain_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_cnt_q       <= '0;
      redirect_pc_q   <= '0;
      last_trap_pc_q  <= '0;
      trap_count_q    <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      seq_cnt_q       <= seq_cnt_d;
      redirect_pc_q   <= redirect_pc_d;
      last_trap_pc_q  <= last_trap_pc_d;
      trap_count_q    <= trap_count_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  assign redirect_pc   = redirect_pc_q;
  assign last_trap_pc  = last_trap_pc_q;
  assign trap_count    = trap_count_q;
  assign drain_timeout = drain_timeout_q;

endmodule

// File: tb/tb_trap_redirect.sv
// Randomised scoreboard bench for trap_redirect: a driver pushes expected redirects,
// a negedge monitor pops and compares them at each fetch handshake.
module tb_trap_redirect;

  localparam int unsigned CW       = 4;
  localparam int unsigned FLUSH    = 2;
  localparam int unsigned DTIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          trap_req = 1'b0, mret_req = 1'b0;
  logic [31:0]   trap_cause = '0, trap_pc = '0, mtvec = '0, mepc = '0;
  logic          lsu_busy = 1'b0, fetch_ready = 1'b0;
  logic          trap_busy, pipe_flush, redirect_valid, drain_timeout;
  logic [31:0]   redirect_pc, last_trap_pc;
  logic [CW-1:0] trap_count;

  trap_redirect #(
    .DRAIN_TIMEOUT(DTIMEOUT),
    .FLUSH_CYCLES (FLUSH),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .trap_req      (trap_req),
    .mret_req      (mret_req),
    .trap_cause    (trap_cause),
    .trap_pc       (trap_pc),
    .mtvec         (mtvec),
    .mepc          (mepc),
    .lsu_busy      (lsu_busy),
    .fetch_ready   (fetch_ready),
    .trap_busy     (trap_busy),
    .pipe_flush    (pipe_flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .last_trap_pc  (last_trap_pc),
    .trap_count    (trap_count),
    .drain_timeout (drain_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [31:0] lpc;
    logic [31:0] dto;
    int          req_cyc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state
  int          m_cnt = 0;
  logic [31:0] m_lpc = '0;
  logic        m_dto = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] target(input logic is_trap, input logic [31:0] tv,
                                         input logic [31:0] cause, input logic [31:0] ep);
    logic [31:0] base;
    if (!is_trap) return ep & 32'hFFFF_FFFC;
    base = tv & 32'hFFFF_FFFC;
    if (tv % 4 == 1 && cause >= 32'h8000_0000)
      return base + (cause & 32'h3FFF_FFFF) * 4;
    return base;
  endfunction

  // Monitor
  int flush_n = 0;
  bit seen_v = 0;
  bit chk_idle = 0;
  always @(negedge clk) begin
    if (!rstn) begin
      flush_n  = 0;
      seen_v   = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        check("idle_after_handshake", {31'b0, trap_busy}, 32'd0);
        chk_idle = 0;
      end
      if (pipe_flush) flush_n++;
      if (redirect_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_redirect: got valid pc 0x%08h expected no redirect",
                   redirect_pc);
        end else begin
          exp_t e;
          e = q[0];
          if (!seen_v) begin
            seen_v = 1;
            check("latency", cyc - e.req_cyc, e.lat);
            check("flush_cycles", flush_n, FLUSH);
          end
          check("redirect_pc", redirect_pc, e.pc);
          if (fetch_ready) begin
            check("trap_count", {{(32-CW){1'b0}}, trap_count}, e.cnt);
            check("last_trap_pc", last_trap_pc, e.lpc);
            check("drain_timeout", {31'b0, drain_timeout}, e.dto);
            void'(q.pop_front());
            seen_v   = 0;
            flush_n  = 0;
            chk_idle = 1;
          end
        end
      end
    end
  end

  // Waits at posedge+1 until the sequencer is idle; returns 0 on timeout.
  task automatic wait_idle(output bit ok);
    int g = 0;
    while (trap_busy && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    ok = !trap_busy;
    if (!ok) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_txn(input bit tr, input bit mr, input logic [31:0] tv,
                        input logic [31:0] cause, input logic [31:0] ep,
                        input logic [31:0] tpc, input int busy, input int stall_pct);
    bit   ok;
    exp_t e;
    int   dlen;
    int   k;
    wait_idle(ok);
    if (!ok) return;
    if (tr || mr) begin
      if (tr) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_lpc = tpc;
      end
      if (busy > int'(DTIMEOUT)) m_dto = 1'b1;
      dlen      = (busy == 0) ? 0 : ((busy > int'(DTIMEOUT)) ? int'(DTIMEOUT) : busy);
      e.pc      = target(tr, tv, cause, ep);
      e.cnt     = m_cnt;
      e.lpc     = m_lpc;
      e.dto     = {31'b0, m_dto};
      e.req_cyc = cyc;
      e.lat     = 1 + dlen + int'(FLUSH);
      q.push_back(e);
    end
    trap_req = tr; mret_req = mr; mtvec = tv; trap_cause = cause; mepc = ep; trap_pc = tpc;
    lsu_busy = (busy > 0);
    fetch_ready = ($urandom_range(0, 99) >= stall_pct);
    @(posedge clk);
    #1;
    k = 1;
    while (trap_busy && k < 200) begin
      lsu_busy    = (k < busy);
      fetch_ready = ($urandom_range(0, 99) >= stall_pct);
      // Requests while busy must be ignored; scramble inputs to expose any leak.
      trap_req    = ($urandom_range(0, 3) == 0);
      mret_req    = ($urandom_range(0, 3) == 0);
      trap_pc     = $urandom;
      mtvec       = $urandom;
      mepc        = $urandom;
      trap_cause  = $urandom;
      @(posedge clk);
      #1;
      k++;
    end
    trap_req = 1'b0; mret_req = 1'b0; lsu_busy = 1'b0;
    if (trap_busy) check("txn_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'b0, trap_busy}, 32'd0);
    check({tag, "_flush"}, {31'b0, pipe_flush}, 32'd0);
    check({tag, "_valid"}, {31'b0, redirect_valid}, 32'd0);
    check({tag, "_pc"}, redirect_pc, 32'd0);
    check({tag, "_lpc"}, last_trap_pc, 32'd0);
    check({tag, "_cnt"}, {{(32-CW){1'b0}}, trap_count}, 32'd0);
    check({tag, "_dto"}, {31'b0, drain_timeout}, 32'd0);
  endtask

  initial begin
    bit ok;
    int g;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    do_txn(1, 0, 32'h0000_0100, 32'h0000_000B, 32'h0, 32'h0000_1000, 0, 0);
    do_txn(1, 0, 32'h0000_0101, 32'h8000_0007, 32'h0, 32'h0000_1004, 0, 0);
    do_txn(1, 0, 32'h0000_0100, 32'h8000_0007, 32'h0, 32'h0000_1008, 0, 0);
    do_txn(0, 1, 32'h0000_0100, 32'h0, 32'h0000_2006, 32'h0000_100C, 0, 0);
    do_txn(1, 1, 32'h0000_0101, 32'h8000_0003, 32'h0000_2006, 32'h0000_1010, 0, 0);
    do_txn(1, 0, 32'h0000_0103, 32'h8000_0005, 32'h0, 32'h0000_1014, 5, 0);
    do_txn(1, 0, 32'hFFFF_FFFD, 32'hBFFF_FFFF, 32'h0, 32'h0000_1018, 0, 80);
    do_txn(0, 1, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 16, 50);
    do_txn(1, 0, 32'h0000_0200, 32'h0000_0002, 32'h0, 32'h0000_101C, 20, 0);
    do_txn(1, 0, 32'h0000_0300, 32'h0000_0002, 32'h0, 32'h0000_1020, 3, 0);

    // Reset while in FLUSH
    wait_idle(ok);
    trap_req = 1'b1; mtvec = 32'h0000_0400; trap_cause = 32'h1; trap_pc = 32'h5555_0000;
    @(posedge clk);
    #1;
    trap_req = 1'b0;
    check("in_flush_before_reset", {31'b0, pipe_flush}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    m_cnt = 0; m_lpc = '0; m_dto = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_idle", {31'b0, trap_busy}, 32'd0);

    // Saturation: more than 2^CW traps
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      do_txn(1, 0, $urandom, $urandom, 32'h0, $urandom, 0, 0);
    end

    // Random mix
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      do_txn(sel != 0, sel <= 1, $urandom, $urandom, $urandom, $urandom,
             $urandom_range(0, 20), $urandom_range(0, 60));
    end

    g = 0;
    while (q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    if (q.size() != 0) check("drain_queue_timeout", q.size(), 32'd0);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trap_redirect.md
Name: trap_redirect

Overview:
- Consumes trap and mret requests raised by the CSR/exception unit in the execute stage.
- Sequences pipeline recovery: drains in-flight load/store traffic, flushes the pipeline, then hands the new PC to fetch over a valid/ready handshake.
- Computes the target PC itself: from mtvec (direct or vectored mode) for traps, from mepc for mret.

Parameters:
DRAIN_TIMEOUT, 16, max cycles spent in DRAIN before forcing progress (>=1)
FLUSH_CYCLES, 2, cycles pipe_flush is held high (>=1)
CNT_W, 16, width of trap_count

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
trap_req  input  1  exception/interrupt request from CSR unit, single-cycle pulse
mret_req  input  1  mret request from CSR unit, single-cycle pulse
trap_cause  input  32  mcause value; bit31 = interrupt
trap_pc  input  32  PC of trapping instruction (latched for debug readback)
mtvec  input  32  trap vector CSR; [1:0] mode, [31:2] base
mepc  input  32  return PC CSR
lsu_busy  input  1  load/store unit has outstanding transaction
fetch_ready  input  1  fetch accepts redirect
trap_busy  output  1  sequencer active; decode must stall
pipe_flush  output  1  kill all instructions younger than trap point
redirect_valid  output  1  redirect_pc valid
redirect_pc  output  32  new fetch PC
last_trap_pc  output  32  trap_pc of most recent accepted trap
trap_count  output  CNT_W  accepted traps (mret excluded), saturating
drain_timeout  output  1  sticky: a DRAIN exited on timeout

Behaviour:
- Reset (async, rstn low): state IDLE; all outputs 0 (redirect_pc, last_trap_pc, trap_count, drain_timeout = 0). Reset mid-sequence aborts with no redirect issued.
- States: IDLE, DRAIN, FLUSH, REDIRECT. trap_busy = (state != IDLE). pipe_flush = (state == FLUSH). redirect_valid = (state == REDIRECT). All are Moore outputs decoded from the state register.

IDLE:
- On trap_req or mret_req, accept the request and latch the target into redirect_pc.
- Both asserted in the same cycle: trap wins; mret is dropped.
- mret target: {mepc[31:2],2'b00}.
- Trap target:
  - If mtvec[1:0]==2'b01 and trap_cause[31]==1: {mtvec[31:2],2'b00} + {trap_cause[29:0],2'b00}, mod 2^32 (wrap, no error).
  - Otherwise: {mtvec[31:2],2'b00}. Mode values 2/3 are treated as direct.
- Accepted trap: last_trap_pc <= trap_pc; trap_count += 1, saturating at all-ones.
- Next state: DRAIN if lsu_busy==1 in the accept cycle, else FLUSH.

DRAIN:
- Counter cleared on entry, increments each cycle.
- Leave for FLUSH when lsu_busy==0, or when counter reaches DRAIN_TIMEOUT-1.
- Timeout exit (lsu_busy still 1) sets drain_timeout. It stays set until reset.

FLUSH:
- Held for exactly FLUSH_CYCLES cycles, then go to REDIRECT.

REDIRECT:
- Hold redirect_valid=1 with redirect_pc stable until fetch_ready==1.
- Transfer completes on the clk edge where redirect_valid && fetch_ready; next state IDLE.

Request handling and latency:
- trap_req/mret_req arriving in any state other than IDLE are ignored (the stalled pipeline guarantees no legitimate overlap).
- A new request is accepted no earlier than the cycle after returning to IDLE.
- Latency, lsu_busy=0 and fetch_ready=1: request at cycle 0; pipe_flush high cycles 1..FLUSH_CYCLES; redirect_valid high cycle FLUSH_CYCLES+1; IDLE at FLUSH_CYCLES+2.

Test Plan:
- Direct trap: mtvec=0x00000100, cause=0x0000000B, trap_req pulse, lsu_busy=0, fetch_ready=1 -> pipe_flush cycles 1-2, redirect_valid cycle 3 with redirect_pc=0x00000100, trap_count=1.
- Vectored interrupt: mtvec=0x00000101, cause=0x80000007 -> redirect_pc=0x0000011C; same cause with mtvec=0x00000100 -> 0x00000100.
- mret with mepc=0x00002006 and simultaneous trap_req/mret_req -> mret alone gives redirect_pc=0x00002004; simultaneous case redirects to the mtvec target and trap_count increments.
- Drain: lsu_busy held 1 for 5 cycles -> DRAIN lasts 5 cycles, drain_timeout=0; lsu_busy stuck 1 -> FLUSH entered after 16 DRAIN cycles, drain_timeout=1 and stays 1 across later traps.
- Backpressure: fetch_ready=0 for 4 cycles in REDIRECT -> redirect_valid and redirect_pc stable; trap_req pulsed meanwhile is ignored (trap_count unchanged); IDLE follows the handshake cycle.
- Reset in FLUSH -> all outputs 0 immediately, no redirect_valid; 2^CNT_W+3 traps -> trap_count saturates at all-ones.
